// File: rtl/rect_drawer.sv
// rect_drawer: raster-scans a WIDTH x HEIGHT rectangle, one pixel per cycle,
// into a 160x120 frame buffer. When built with RECT_DRAWER_ERASE_EN defined,
// the previous rectangle is first repainted in BG_COLOR before the new one is
// drawn. Without the macro, every start draws only.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      draw request, sampled only in IDLE
//   x_in/y_in  top-left corner of the new rectangle (8b column / 7b row)
//   color_in   fill colour of the new rectangle
//   busy       high while pixels are being emitted
//   done       one-cycle pulse after the last drawn pixel
//   x_out/y_out/color_out  current pixel (registered)
//   plot       current pixel is an on-screen frame-buffer write
module rect_drawer #(
  parameter int         WIDTH    = 4,
  parameter int         HEIGHT   = 4,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] color_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] color_out,
  output logic       plot
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FIN   = 2'd2
`ifdef RECT_DRAWER_ERASE_EN
    , ERASE = 2'd3
`endif
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [7:0]    new_x;
  logic [6:0]    new_y;
  logic [2:0]    new_col;
`ifdef RECT_DRAWER_ERASE_EN
  logic [7:0]    prev_x;
  logic [6:0]    prev_y;
  logic          prev_valid;
`endif

  logic       accept, last_px, emit;
  logic [7:0] bx, px, x_n;
  logic [6:0] by, py, y_n;
  logic [2:0] bc, c_n;
  logic       busy_n, done_n, plot_n;

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    accept  = (state == IDLE) && start;
    last_px = (col == COL_LAST) && (row == ROW_LAST);

    case (state)
      IDLE: if (start) begin
        col_n = '0;
        row_n = '0;
`ifdef RECT_DRAWER_ERASE_EN
        state_n = prev_valid ? ERASE : DRAW;
`else
        state_n = DRAW;
`endif
      end
`ifdef RECT_DRAWER_ERASE_EN
      ERASE: begin
        if (last_px) begin
          state_n = DRAW;
          col_n   = '0;
          row_n   = '0;
        end else if (col == COL_LAST) begin
          col_n = '0;
          row_n = row + 1'b1;
        end else begin
          col_n = col + 1'b1;
        end
      end
`endif
      DRAW: begin
        if (last_px) begin
          state_n = FIN;
        end else if (col == COL_LAST) begin
          col_n = '0;
          row_n = row + 1'b1;
        end else begin
          col_n = col + 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are computed for the pixel the *next* state will show, so the
    // first pixel is on the ports the cycle after start is accepted. During
    // the accept cycle the new_* latches are not loaded yet, so the raw
    // inputs supply the base.
    bx = accept ? x_in : new_x;
    by = accept ? y_in : new_y;
    bc = (state_n == DRAW) ? (accept ? color_in : new_col) : BG_COLOR;
`ifdef RECT_DRAWER_ERASE_EN
    if (state_n == ERASE) begin
      bx = prev_x;
      by = prev_y;
    end
    emit = (state_n == DRAW) || (state_n == ERASE);
`else
    emit = (state_n == DRAW);
`endif

    px     = bx + 8'(col_n);
    py     = by + 7'(row_n);
    x_n    = x_out;
    y_n    = y_out;
    c_n    = color_out;
    plot_n = 1'b0;
    busy_n = emit;
    done_n = (state_n == FIN);
    if (emit) begin
      x_n    = px;
      y_n    = py;
      c_n    = bc;
      plot_n = (px <= 8'd159) && (py <= 7'd119);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      new_x      <= '0;
      new_y      <= '0;
      new_col    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      color_out  <= '0;
`ifdef RECT_DRAWER_ERASE_EN
      prev_x     <= '0;
      prev_y     <= '0;
      prev_valid <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      busy      <= busy_n;
      done      <= done_n;
      plot      <= plot_n;
      x_out     <= x_n;
      y_out     <= y_n;
      color_out <= c_n;
      if (accept) begin
        new_x   <= x_in;
        new_y   <= y_in;
        new_col <= color_in;
      end
`ifdef RECT_DRAWER_ERASE_EN
      // Only a fully completed rectangle becomes erasable.
      if (state == DRAW && state_n == FIN) begin
        prev_x     <= new_x;
        prev_y     <= new_y;
        prev_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/rect_drawer.md
RECT_DRAWER -- requirements
Module: rect_drawer

Interface
REQ-001 Parameter WIDTH, default 4: rectangle width in pixels, 1..16.
REQ-002 Parameter HEIGHT, default 4: rectangle height in pixels, 1..16.
REQ-003 Parameter BG_COLOR, default 3'b000: colour used when erasing.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request to draw one rectangle; sampled only in IDLE.
REQ-007 x_in  input  8  top-left column of the new rectangle.
REQ-008 y_in  input  7  top-left row of the new rectangle.
REQ-009 color_in  input  3  fill colour of the new rectangle.
REQ-010 busy  output  1  high while in ERASE or DRAW.
REQ-011 done  output  1  one-cycle pulse after the last DRAW pixel.
REQ-012 x_out  output  8  current pixel column.
REQ-013 y_out  output  7  current pixel row.
REQ-014 color_out  output  3  current pixel colour.
REQ-015 plot  output  1  current pixel is a valid write to the frame buffer.

Function
REQ-016 States: IDLE, ERASE, DRAW, FIN; all outputs registered.
REQ-017 IDLE and start=1: latch x_in/y_in/color_in into new_x/new_y/new_col; go to ERASE if prev_valid=1, else DRAW; zero col and row counters.
REQ-018 Latched inputs are held for the whole operation; x_in/y_in/color_in changes while busy have no effect.
REQ-019 start while busy, or in FIN, is ignored with no queuing.
REQ-020 Pixel order raster: col 0..WIDTH-1 inner, row 0..HEIGHT-1 outer; one pixel per cycle.
REQ-021 ERASE emits x_out=prev_x+col, y_out=prev_y+row, color_out=BG_COLOR.
REQ-022 DRAW emits x_out=new_x+col, y_out=new_y+row, color_out=new_col.
REQ-023 Address sums are truncated to port width (8-bit / 7-bit wrap-around).
REQ-024 plot=1 only in ERASE/DRAW and only when x_out<=159 and y_out<=119; off-screen pixels still consume their cycle with plot=0.
REQ-025 First pixel appears the cycle after start is accepted; one operation lasts WIDTH*HEIGHT cycles (DRAW only) or 2*WIDTH*HEIGHT cycles (ERASE+DRAW), plus one FIN cycle.
REQ-026 After the last ERASE pixel go directly to DRAW with no gap cycle; counters reset to zero.
REQ-027 After the last DRAW pixel enter FIN: done=1, plot=0, busy=0; copy new_x/new_y into prev_x/prev_y; set prev_valid=1; next cycle IDLE.
REQ-028 In IDLE and FIN, x_out/y_out hold their last value and color_out holds its last value; plot=0.

Reset
REQ-029 reset=0 at a clock edge: state IDLE, busy=0, done=0, plot=0, x_out=0, y_out=0, color_out=0, counters=0, prev_valid=0, prev_x=0, prev_y=0.
REQ-030 Reset mid-operation aborts immediately; the partially drawn rectangle is not erased by the next operation.

Configuration
REQ-031 Macro RECT_DRAWER_ERASE_EN defined: ERASE phase behaves as REQ-017/021/026.
REQ-032 Macro RECT_DRAWER_ERASE_EN undefined: ERASE state and prev_x/prev_y/prev_valid are absent; every start goes directly to DRAW; latency is WIDTH*HEIGHT+1 cycles.

Verification
REQ-033 After reset, start with x_in=10, y_in=20, color_in=3'b100 -> 16 plot pulses covering (10..13,20..23) colour 100, no erase, done pulse at cycle 17.
REQ-034 Second start with x_in=11, y_in=20, color_in=3'b100 (ERASE_EN) -> 16 BG_COLOR pixels at (10..13,20..23), then 16 pixels at (11..14,20..23), done at cycle 33.
REQ-035 Start with x_in=158, y_in=118 -> 16 cycles; plot=1 only for x in 158..159 and y in 118..119 (4 pixels).
REQ-036 Start with x_in=254 -> x_out sequence 254,255,0,1 per row; plot=0 for 254,255 and 1 for 0,1.
REQ-037 Start pulsed again at pixel 5 and x_in changed to 50 -> ignored; all pixels use the originally latched position.
REQ-038 reset=0 at pixel 7 -> next cycle plot=0, busy=0, done=0; following start performs no ERASE.
